// File: rtl/var_delay_buffer_pkg.sv
// Shared definitions for the variable-delay buffer: delay-port width
// derivation and the clamp applied to requested delays.
package var_delay_buffer_pkg;

    // Width needed to hold any delay value from 0 up to max_delay inclusive.
    function automatic int delay_width(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Map a requested delay onto the legal range 1..max_delay.
    // A request of 0 would select no stage at all, so it becomes 1.
    function automatic int clamp_delay(input int req, input int max_delay);
        if (req < 1) begin
            return 1;
        end else if (req > max_delay) begin
            return max_delay;
        end
        return req;
    endfunction

endpackage

// File: rtl/var_delay_buffer_stage.sv
// One physical stage of the delay line: an enabled register holding the
// sample data together with its valid tag.
module delay_stage #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Capture the incoming word when enabled; clear asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/var_delay_buffer.sv
// Variable-delay buffer: a fixed chain of MAX_DELAY stages with a runtime
// selectable output tap. A configuration load picks a new tap, wipes the
// valid tags so stale samples never appear, and restarts the fill counter.
module var_delay_buffer
    import var_delay_buffer_pkg::*;
#(
    parameter  int WIDTH         = 8,
    parameter  int MAX_DELAY     = 16,
    parameter  int DEFAULT_DELAY = 2,
    localparam int DW            = delay_width(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_in_valid,
    input  logic [DW-1:0]    cfg_delay,
    input  logic             cfg_load,
    output logic [WIDTH-1:0] d_out,
    output logic             d_out_valid,
    output logic             primed,
    output logic [DW-1:0]    cur_delay
);

    // Each stage word is {data, valid}; valid sits in bit 0.
    localparam int SW = WIDTH + 1;

    logic [SW-1:0] stage_d [MAX_DELAY];
    logic [SW-1:0] stage_q [MAX_DELAY];
    logic          stage_en;
    logic [DW-1:0] cur_delay_d, cur_delay_q;
    logic [DW-1:0] fill_cnt_d, fill_cnt_q;
    logic [SW-1:0] tap;

    // A load must touch every stage (to drop valid tags) even with en low.
    assign stage_en = en | cfg_load;

    // Stage inputs: on a load each stage reloads its own data with the valid
    // tag cleared, so the incoming sample is dropped; otherwise shift by one.
    always_comb begin
        if (cfg_load) begin
            stage_d[0] = {stage_q[0][SW-1:1], 1'b0};
        end else begin
            stage_d[0] = {d_in, d_in_valid};
        end
        for (int k = 1; k < MAX_DELAY; k++) begin
            if (cfg_load) begin
                stage_d[k] = {stage_q[k][SW-1:1], 1'b0};
            end else begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    for (genvar g = 0; g < MAX_DELAY; g++) begin : g_stage
        delay_stage #(
            .W (SW)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en_i (stage_en),
            .d_i  (stage_d[g]),
            .q_o  (stage_q[g])
        );
    end

    // Next active delay and fill count: a load restarts filling at the new
    // delay; enabled cycles count up until the pipeline is full.
    always_comb begin
        cur_delay_d = cur_delay_q;
        fill_cnt_d  = fill_cnt_q;
        if (cfg_load) begin
            cur_delay_d = DW'(clamp_delay(int'(cfg_delay), MAX_DELAY));
            fill_cnt_d  = '0;
        end else if (en && (fill_cnt_q < cur_delay_q)) begin
            fill_cnt_d = fill_cnt_q + DW'(1);
        end
    end

    // Control registers, returning to the default delay on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_delay_q <= DW'(DEFAULT_DELAY);
            fill_cnt_q  <= '0;
        end else begin
            cur_delay_q <= cur_delay_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end

    // Output tap: select stage[cur_delay-1] straight from the registers.
    always_comb begin
        tap = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (cur_delay_q == DW'(k + 1)) begin
                tap = stage_q[k];
            end
        end
    end

    assign d_out       = tap[SW-1:1];
    assign d_out_valid = tap[0];
    assign primed      = (fill_cnt_q == cur_delay_q);
    assign cur_delay   = cur_delay_q;

endmodule

// File: tb/tb_var_delay_buffer.sv
// Self-checking bench for var_delay_buffer (WIDTH=8, MAX_DELAY=16,
// DEFAULT_DELAY=2): a table of directed vectors plus hand-written
// sequences for asynchronous reset behaviour.
module tb_var_delay_buffer;

    localparam int WIDTH = 8;
    localparam int MAXD  = 16;
    localparam int DW    = 5;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] d_in;
    logic             d_in_valid;
    logic [DW-1:0]    cfg_delay;
    logic             cfg_load;
    logic [WIDTH-1:0] d_out;
    logic             d_out_valid;
    logic             primed;
    logic [DW-1:0]    cur_delay;

    int nVectors = 0;
    int nFail    = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] d;
        logic       dv;
        logic [4:0] cfg;
        logic       ld;
        logic       chkD;
        logic [7:0] expD;
        logic       expV;
        logic       expP;
        logic [4:0] expCur;
    } vec_t;

    vec_t vecs[$];

    var_delay_buffer #(
        .WIDTH         (WIDTH),
        .MAX_DELAY     (MAXD),
        .DEFAULT_DELAY (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .d_in        (d_in),
        .d_in_valid  (d_in_valid),
        .cfg_delay   (cfg_delay),
        .cfg_load    (cfg_load),
        .d_out       (d_out),
        .d_out_valid (d_out_valid),
        .primed      (primed),
        .cur_delay   (cur_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] d,
                                input logic dv, input logic [4:0] cfg, input logic ld,
                                input logic chkD, input logic [7:0] expD, input logic expV,
                                input logic expP, input logic [4:0] expCur);
        vec_t v;
        v.rst = r; v.en = e; v.d = d; v.dv = dv; v.cfg = cfg; v.ld = ld;
        v.chkD = chkD; v.expD = expD; v.expV = expV; v.expP = expP; v.expCur = expCur;
        return v;
    endfunction

    // Drive one set of inputs at the falling edge, then let the rising edge occur.
    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] d,
                                 input logic dv, input logic [4:0] cfg, input logic ld);
        @(negedge clk);
        rst = r; en = e; d_in = d; d_in_valid = dv; cfg_delay = cfg; cfg_load = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic chkD, input logic [7:0] expD,
                               input logic expV, input logic expP, input logic [4:0] expCur);
        logic bad;
        nVectors++;
        bad = (d_out_valid !== expV) || (primed !== expP) || (cur_delay !== expCur) ||
              (chkD && (d_out !== expD));
        if (bad) begin
            nFail++;
            $display("[TB] FAIL %s: got d_out=%h valid=%b primed=%b cur_delay=%0d, expected d_out=%h%s valid=%b primed=%b cur_delay=%0d",
                     tag, d_out, d_out_valid, primed, cur_delay, expD, chkD ? "" : "(any)",
                     expV, expP, expCur);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; d_in = '0; d_in_valid = 1'b0; cfg_delay = '0; cfg_load = 1'b0;

        // Reset, then stream 1,2,3,4 at the default delay of 2.
        vecs.push_back(mk(1,0,8'h00,0,0,0, 1,8'h00,0,0,2));
        vecs.push_back(mk(0,1,8'h01,1,0,0, 1,8'h00,0,0,2));
        vecs.push_back(mk(0,1,8'h02,1,0,0, 1,8'h01,1,1,2));
        vecs.push_back(mk(0,1,8'h03,1,0,0, 1,8'h02,1,1,2));
        vecs.push_back(mk(0,1,8'h04,1,0,0, 1,8'h03,1,1,2));
        vecs.push_back(mk(0,0,8'h99,1,0,0, 1,8'h03,1,1,2));
        // Load delay 5 with en high (0xAA dropped), then stream A0..A5.
        vecs.push_back(mk(0,1,8'hAA,1,5,1, 1,8'h00,0,0,5));
        vecs.push_back(mk(0,1,8'hA0,1,0,0, 0,8'h00,0,0,5));
        vecs.push_back(mk(0,1,8'hA1,1,0,0, 0,8'h00,0,0,5));
        vecs.push_back(mk(0,1,8'hA2,1,0,0, 0,8'h00,0,0,5));
        vecs.push_back(mk(0,1,8'hA3,1,0,0, 0,8'h00,0,0,5));
        vecs.push_back(mk(0,1,8'hA4,1,0,0, 1,8'hA0,1,1,5));
        vecs.push_back(mk(0,1,8'hA5,1,0,0, 1,8'hA1,1,1,5));
        // Load delay 3 with en low, then toggle en 1,0,1,0,1,0.
        vecs.push_back(mk(0,0,8'h00,0,3,1, 0,8'h00,0,0,3));
        vecs.push_back(mk(0,1,8'h55,1,0,0, 0,8'h00,0,0,3));
        vecs.push_back(mk(0,0,8'h00,0,0,0, 0,8'h00,0,0,3));
        vecs.push_back(mk(0,1,8'h66,1,0,0, 0,8'h00,0,0,3));
        vecs.push_back(mk(0,0,8'h00,0,0,0, 0,8'h00,0,0,3));
        vecs.push_back(mk(0,1,8'h77,1,0,0, 1,8'h55,1,1,3));
        vecs.push_back(mk(0,0,8'h88,1,0,0, 1,8'h55,1,1,3));
        // Delay 0 clamps to 1; 0xEE arriving with the load never appears.
        vecs.push_back(mk(0,1,8'hEE,1,0,1, 1,8'h77,0,0,1));
        vecs.push_back(mk(0,1,8'h12,1,0,0, 1,8'h12,1,1,1));
        // Delay MAX+3 clamps to MAX; immediately overridden by a load of 4.
        vecs.push_back(mk(0,1,8'h34,1,19,1, 0,8'h00,0,0,16));
        vecs.push_back(mk(0,0,8'h00,0,4,1, 0,8'h00,0,0,4));
        // Valid pattern 1,0,1,1 reproduced four edges later.
        vecs.push_back(mk(0,1,8'hC1,1,0,0, 0,8'h00,0,0,4));
        vecs.push_back(mk(0,1,8'hC2,0,0,0, 0,8'h00,0,0,4));
        vecs.push_back(mk(0,1,8'hC3,1,0,0, 0,8'h00,0,0,4));
        vecs.push_back(mk(0,1,8'hC4,1,0,0, 1,8'hC1,1,1,4));
        vecs.push_back(mk(0,1,8'h00,0,0,0, 1,8'hC2,0,1,4));
        vecs.push_back(mk(0,1,8'h00,0,0,0, 1,8'hC3,1,1,4));
        vecs.push_back(mk(0,1,8'h00,0,0,0, 1,8'hC4,1,1,4));
        vecs.push_back(mk(0,1,8'h00,0,0,0, 1,8'h00,0,1,4));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].dv, vecs[i].cfg, vecs[i].ld);
            checkOutput($sformatf("vec%0d", i), vecs[i].chkD, vecs[i].expD,
                        vecs[i].expV, vecs[i].expP, vecs[i].expCur);
        end

        // Delay 7: stream B0..B7, B0 must emerge on the 7th enabled edge.
        applyStimulus(0, 1, 8'h00, 0, 7, 1);
        checkOutput("load7", 1'b0, 8'h00, 0, 0, 7);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 8'hB0 + 8'(i), 1, 0, 0);
            if (i < 6) begin
                checkOutput($sformatf("d7_fill%0d", i), 1'b0, 8'h00, 0, 0, 7);
            end else begin
                checkOutput($sformatf("d7_out%0d", i), 1'b1, 8'hB0 + 8'(i - 6), 1, 1, 7);
            end
        end

        // Asynchronous reset mid-cycle while streaming.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 1'b1, 8'h00, 0, 0, 2);
        @(posedge clk);
        #1;
        checkOutput("rst_held", 1'b1, 8'h00, 0, 0, 2);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("rst_release", 1'b1, 8'h00, 0, 0, 2);

        // Reset arriving while a load is being requested must win.
        @(negedge clk);
        cfg_delay = 5'd9; cfg_load = 1'b1; en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_during_load", 1'b1, 8'h00, 0, 0, 2);
        applyStimulus(0, 1, 8'hD1, 1, 0, 0);
        checkOutput("post_rst_1", 1'b1, 8'h00, 0, 0, 2);
        applyStimulus(0, 1, 8'hD2, 1, 0, 0);
        checkOutput("post_rst_2", 1'b1, 8'hD1, 1, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

endmodule
